uart_rx: RTL

Asynchronous serial receiver, the receive counterpart of the team's UART transmitter. It accepts an 8N1 frame on `in__rx`: idle high, one start bit 0, eight data bits LSB first, one stop bit 1, with each bit lasting `CLKS_PER_BIT` clock cycles. It delivers each received byte on a valid/ready output port and flags framing and overrun errors. It sits at the chip pin, facing the same line discipline the transmitter drives.

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer,
// valid/ready byte output, sticky overrun and one-cycle framing-error pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in__rx,
  output logic [7:0] out__data,
  output logic       out__valid,
  input  logic       in__ready,
  output logic       out__overrun,
  output logic       out__frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ctr, ctr_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          sync1, rxs;
  logic          load, ferr;
  logic          accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= in__rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ctr     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      state   <= state_nxt;
      ctr     <= ctr_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    load      = 1'b0;
    ferr      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_nxt = S_START;
          ctr_nxt   = '0;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects short glitches on the line.
        if (ctr == HALF) begin
          ctr_nxt = '0;
          if (rxs) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            bit_nxt   = 3'd0;
          end
        end else begin
          ctr_nxt = ctr + CW'(1);
        end
      end
      S_DATA: begin
        if (ctr == LAST) begin
          ctr_nxt   = '0;
          shift_nxt = {rxs, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          ctr_nxt = ctr + CW'(1);
        end
      end
      S_STOP: begin
        if (ctr == LAST) begin
          ctr_nxt = '0;
          if (rxs) begin
            load      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = S_BREAK;
          end
        end else begin
          ctr_nxt = ctr + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        ctr_nxt   = '0;
      end
    endcase
  end

  assign accept = out__valid & in__ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out__data      <= 8'd0;
      out__valid     <= 1'b0;
      out__overrun   <= 1'b0;
      out__frame_err <= 1'b0;
    end else begin
      out__frame_err <= ferr;
      if (load) out__data <= shift;
      out__valid <= load | (out__valid & ~in__ready);
      // A load onto an unaccepted byte sets overrun; this takes priority over clearing.
      if (load && out__valid && !in__ready) begin
        out__overrun <= 1'b1;
      end else if (accept) begin
        out__overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
